fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, width of write data.
REQ-002 SHALL have parameter BURST_MAX, default 4, max accepted beats per grant (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req0_valid  input  1  producer 0 has a data beat.
REQ-006 SHALL have port req0_data  input  FIFO_WIDTH  producer 0 beat.
REQ-007 SHALL have port req0_ready  output  1  producer 0 beat accepted this cycle.
REQ-008 SHALL have port req1_valid  input  1  producer 1 has a data beat.
REQ-009 SHALL have port req1_data  input  FIFO_WIDTH  producer 1 beat.
REQ-010 SHALL have port req1_ready  output  1  producer 1 beat accepted this cycle.
REQ-011 SHALL have port full  input  1  FIFO full flag.
REQ-012 SHALL have port almostfull  input  1  FIFO one-slot-left flag.
REQ-013 SHALL have port overflow  input  1  FIFO rejected a write.
REQ-014 SHALL have port wr_en  output  1  registered FIFO write enable.
REQ-015 SHALL have port data_in  output  FIFO_WIDTH  registered FIFO write data.
REQ-016 SHALL have port grant  output  2  one-hot current owner, 2'b00 when idle.
REQ-017 SHALL have port ovf_cnt  output  8  saturating count of overflow pulses.

Function
REQ-018 SHALL implement FSM states IDLE, GNT0, GNT1; grant = 01 in GNT0, 10 in GNT1, 00 in IDLE.
REQ-019 SHALL move IDLE->GNTx the cycle after reqx_valid is seen; ready is never asserted in IDLE.
REQ-020 SHALL, with both valid in IDLE, grant the producer not served last (last_served pointer; producer 0 wins after reset).
REQ-021 SHALL drive reqx_ready = (state==GNTx) && reqx_valid && !full && !(almostfull && wr_en), combinationally.
REQ-022 SHALL, on accept (valid && ready), register wr_en=1 and data_in=reqx_data next cycle; otherwise wr_en=0 and data_in holds.
REQ-023 SHALL keep a beat counter, cleared on entering GNTx, incremented per accept.
REQ-024 SHALL release GNTx when reqx_valid is low or beat counter reaches BURST_MAX on an accept.
REQ-025 SHALL on release go to the other GNT if the other valid is high, else re-enter GNTx (counter cleared) if reqx_valid still high, else IDLE; last_served<=x.
REQ-026 SHALL hold grant while backpressured (ready low due to full) with valid high; stalled cycles do not count.
REQ-027 SHALL never issue two FIFO writes per cycle nor accept from the non-granted producer.
REQ-028 SHALL increment ovf_cnt per overflow=1 cycle, saturating at 255.

Reset
REQ-029 SHALL on rst=1 at a clock edge set state=IDLE, grant=00, wr_en=0, data_in=0, ovf_cnt=0, beat counter=0, last_served=1; ready low during rst.
REQ-030 SHALL, if rst asserts mid-burst, drop any in-flight beat (wr_en=0 next cycle) and restart arbitration at producer 0.

Verification
REQ-031 Single producer: req0_valid=1, data 0x0001..0x0006, BURST_MAX=4 -> grant 01 throughout, 6 writes in order, one re-grant gap cycle after beat 4.
REQ-032 Contention: both valid from IDLE -> grant 01 first, 4 writes of producer 0, then grant 10, 4 writes of producer 1, alternating.
REQ-033 Backpressure: full=1 during GNT1 for 3 cycles -> req1_ready=0, wr_en=0, grant stays 10, beat counter unchanged; resumes when full=0.
REQ-034 Almost-full guard: almostfull=1 and wr_en=1 -> ready=0 that cycle; no overflow from the arbiter's own writes.
REQ-035 Overflow counter: 300 overflow pulses -> ovf_cnt=255 and holds.
REQ-036 Reset mid-burst: rst=1 after 2 accepts of producer 1 -> next cycle grant=00, wr_en=0, ovf_cnt=0; both valid afterwards -> grant 01.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-producer write arbiter in front of a single FIFO.
// One producer owns the FIFO write port at a time, for bursts of up to BURST_MAX
// accepted beats. Ownership passes round-robin when both producers are waiting.
// The FIFO write enable and write data are registered, and overflow pulses from
// the FIFO are counted in a saturating counter.
module fifo_wr_arbiter #(
   parameter int FIFO_WIDTH = 16,
   parameter int BURST_MAX  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [FIFO_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [FIFO_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   input  logic                  full,
   input  logic                  almostfull,
   input  logic                  overflow,
   output logic                  wr_en,
   output logic [FIFO_WIDTH-1:0] data_in,
   output logic [1:0]            grant,
   output logic [7:0]            ovf_cnt
);

   // Each state's encoding is the grant value it drives.
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_GNT0 = 2'b01;
   localparam logic [1:0] S_GNT1 = 2'b10;

   localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  gap_q, gap_d;
   logic                  wr_en_q;
   logic [FIFO_WIDTH-1:0] data_q;
   logic [7:0]            ovf_q;

   logic [1:0]            valid_vec;
   logic [1:0]            ready_vec;
   logic [1:0]            acc_vec;
   logic                  wr_guard;
   logic                  accept;
   logic [FIFO_WIDTH-1:0] acc_data;
   logic                  own;

   assign valid_vec = {req1_valid, req0_valid};

   // A beat may be taken only if the FIFO has room. If only one slot is left
   // and a write is already in flight, that slot is spoken for. The first
   // cycle after a producer is re-granted to itself is a dead cycle.
   assign wr_guard = !rst && !full && !(almostfull && wr_en_q) && !gap_q;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         localparam logic [1:0] OWN_STATE = (gi == 0) ? S_GNT0 : S_GNT1;
         assign ready_vec[gi] = wr_guard && valid_vec[gi] && (state_q == OWN_STATE);
         assign acc_vec[gi]   = valid_vec[gi] && ready_vec[gi];
      end
   endgenerate

   assign req0_ready = ready_vec[0];
   assign req1_ready = ready_vec[1];
   assign accept     = |acc_vec;
   assign acc_data   = acc_vec[1] ? req1_data : req0_data;

   // Arbitration: pick an owner from idle, count beats, and decide on release.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gap_d   = 1'b0;
      own     = (state_q == S_GNT1);
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            if (valid_vec[0] && valid_vec[1]) begin
               state_d = last_q ? S_GNT0 : S_GNT1;
            end else if (valid_vec[0]) begin
               state_d = S_GNT0;
            end else if (valid_vec[1]) begin
               state_d = S_GNT1;
            end
         end
         S_GNT0, S_GNT1: begin
            if (accept) begin
               cnt_d = cnt_q + 4'd1;
            end
            // Stalled cycles (valid high, not accepted) neither count nor release.
            if (!valid_vec[own] || (accept && ((cnt_q + 4'd1) == BURST_LIM))) begin
               last_d = own;
               cnt_d  = 4'd0;
               if (valid_vec[~own]) begin
                  state_d = own ? S_GNT0 : S_GNT1;
               end else if (valid_vec[own]) begin
                  gap_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State, write-port and overflow-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         last_q  <= 1'b1;
         gap_q   <= 1'b0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         wr_en_q <= accept;
         if (accept) begin
            data_q <= acc_data;
         end
         if (overflow && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 8'd1;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign data_in = data_q;
   assign grant   = state_q;
   assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter. A behavioural model
// predicts owner, readiness and accepted beats. Accepted beats are queued, and a
// monitor pops one entry for every FIFO write the DUT issues.
module tb_fifo_wr_arbiter;

   localparam int W  = 16;
   localparam int BM = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0;
   logic [W-1:0] req0_data  = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req1_data  = '0;
   logic         req1_ready;
   logic         full       = 1'b0;
   logic         almostfull = 1'b0;
   logic         overflow   = 1'b0;
   logic         wr_en;
   logic [W-1:0] data_in;
   logic [1:0]   grant;
   logic [7:0]   ovf_cnt;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.FIFO_WIDTH(W), .BURST_MAX(BM)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .full       (full),
      .almostfull (almostfull),
      .overflow   (overflow),
      .wr_en      (wr_en),
      .data_in    (data_in),
      .grant      (grant),
      .ovf_cnt    (ovf_cnt)
   );

   int           n_vec  = 0;
   int           n_miss = 0;
   int           dut_wr_cnt = 0;
   bit           mon_en = 1'b0;
   logic [W-1:0] sb[$];

   // Reference model: owner -1 means nobody holds the write port.
   int           m_owner = -1;
   int           m_beats = 0;
   int           m_last  = 1;
   int           m_ovf   = 0;
   bit           m_gap   = 1'b0;
   bit           m_wr    = 1'b0;
   logic [W-1:0] m_data  = '0;

   // Producers: beats still to send and next data word.
   int           p_left[2]  = '{0, 0};
   logic [W-1:0] p_next[2]  = '{16'h0001, 16'h1001};
   int           acc_cnt[2] = '{0, 0};

   function automatic void check(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every DUT write must match the oldest predicted beat.
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_en) begin
            dut_wr_cnt++;
            if (sb.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_write: got data %0h expected no write", data_in);
            end else begin
               logic [W-1:0] exp_d;
               exp_d = sb.pop_front();
               $display("write data=%04h expected=%04h", data_in, exp_d);
               check("wr_data", int'(data_in), int'(exp_d));
            end
         end else if (sb.size() > 0) begin
            logic [W-1:0] lost;
            lost = sb.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL missing_write: got no write expected data %0h", lost);
         end
      end
   end

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input bit r, input bit f, input bit af, input bit ov, input int vprob);
      bit v[2];
      bit rdy[2];
      bit acc[2];
      int ge;
      int x;
      bit rel;
      bit nxt_gap;
      @(negedge clk);
      rst        = r;
      full       = f;
      almostfull = af;
      overflow   = ov;
      for (int i = 0; i < 2; i++) begin
         v[i] = (p_left[i] > 0) && ($urandom_range(0, 99) < vprob);
      end
      req0_valid = v[0];
      req0_data  = p_next[0];
      req1_valid = v[1];
      req1_data  = p_next[1];
      #1;
      for (int i = 0; i < 2; i++) begin
         rdy[i] = !r && (m_owner == i) && v[i] && !f && !(af && m_wr) && !m_gap;
         acc[i] = v[i] && rdy[i];
      end
      ge = (m_owner == 0) ? 1 : (m_owner == 1) ? 2 : 0;
      check("grant", int'(grant), ge);
      check("req0_ready", int'(req0_ready), int'(rdy[0]));
      check("req1_ready", int'(req1_ready), int'(rdy[1]));
      check("ovf_cnt", int'(ovf_cnt), m_ovf);
      check("data_in", int'(data_in), int'(m_data));
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) begin
            sb.push_back(p_next[i]);
            m_data = p_next[i];
            p_next[i] = p_next[i] + 1'b1;
            p_left[i]--;
            acc_cnt[i]++;
         end
      end
      if (r) begin
         m_owner = -1;
         m_beats = 0;
         m_last  = 1;
         m_gap   = 1'b0;
         m_wr    = 1'b0;
         m_data  = '0;
         m_ovf   = 0;
      end else begin
         m_wr = acc[0] || acc[1];
         if (ov && m_ovf < 255) m_ovf++;
         nxt_gap = 1'b0;
         if (m_owner < 0) begin
            if (v[0] && v[1]) m_owner = (m_last == 0) ? 1 : 0;
            else if (v[0]) m_owner = 0;
            else if (v[1]) m_owner = 1;
            m_beats = 0;
         end else begin
            x   = m_owner;
            rel = 1'b0;
            if (acc[x]) begin
               m_beats++;
               if (m_beats == BM) rel = 1'b1;
            end
            if (!v[x]) rel = 1'b1;
            if (rel) begin
               m_last  = x;
               m_beats = 0;
               if (v[1-x]) m_owner = 1 - x;
               else if (v[x]) nxt_gap = 1'b1;
               else m_owner = -1;
            end
         end
         m_gap = nxt_gap;
      end
   endtask

   initial begin
      int wr_base;
      int a_base;
      mon_en = 1'b1;

      // Reset state.
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("reset_wr_en", int'(wr_en), 0);

      // Single producer, six beats with a burst limit of four.
      wr_base   = dut_wr_cnt;
      p_left[0] = 6;
      p_next[0] = 16'h0001;
      repeat (14) step(1'b0, 1'b0, 1'b0, 1'b0, 100);
      check("single_writes", dut_wr_cnt - wr_base, 6);

      // Contention from reset: producer 0 first, then alternating bursts.
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      wr_base   = dut_wr_cnt;
      p_left[0] = 8;
      p_left[1] = 8;
      repeat (26) step(1'b0, 1'b0, 1'b0, 1'b0, 100);
      check("contention_writes", dut_wr_cnt - wr_base, 16);

      // Backpressure during a producer 1 burst.
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      p_left[1] = 6;
      for (int i = 0; i < 14; i++) step(1'b0, (i >= 3 && i < 6), 1'b0, 1'b0, 100);

      // Almost-full guard: one slot left throughout, then random.
      p_left[0] = 20;
      repeat (15) step(1'b0, 1'b0, 1'b1, 1'b0, 100);
      repeat (20) step(1'b0, 1'b0, ($urandom_range(0, 1) == 1), 1'b0, 100);
      p_left[0] = 0;
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Overflow counter saturation.
      repeat (300) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("ovf_saturated", int'(ovf_cnt), 255);

      // Reset in the middle of a producer 1 burst.
      p_left[1] = 10;
      a_base    = acc_cnt[1];
      for (int i = 0; i < 20 && (acc_cnt[1] - a_base) < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 100);
      step(1'b1, 1'b0, 1'b0, 1'b0, 100);
      p_left[0] = 5;
      p_left[1] = 5;
      step(1'b0, 1'b0, 1'b0, 1'b0, 100);
      check("post_reset_wr_en", int'(wr_en), 0);
      repeat (16) step(1'b0, 1'b0, 1'b0, 1'b0, 100);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (p_left[p] == 0 && $urandom_range(0, 99) < 10) p_left[p] = $urandom_range(1, 12);
         end
         step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 5), 70);
      end

      // Drain: every predicted write must have appeared.
      p_left[0] = 0;
      p_left[1] = 0;
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
